// File: rtl/omem_pkg.sv
// omem_pkg: shared constants, readout state encoding and FIFO entry type for omem_seq
package omem_pkg;
  localparam int OMEM_DEPTH = 75;
  localparam int OMEM_AW = 7;
  localparam int OMEM_DW = 9;
  typedef enum logic [1:0] {IDLE, DUMP, DRAIN} state_e;
  typedef struct packed {
    logic [OMEM_AW-1:0] addr;
    logic [OMEM_DW-1:0] data;
  } entry_t;
endpackage

// File: rtl/omem_seq_fifo2.sv
// omem_seq_fifo2: 2-entry shifting FIFO with count, allows push and pop in the same cycle
module omem_seq_fifo2 import omem_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);
  entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, slot;
  always_comb begin
    slot = cnt_q - {1'b0, pop};
    cnt_d = slot + {1'b0, push};
    e0_d = (push && slot == 2'd0) ? din : pop ? e1_q : e0_q;
    e1_d = (push && slot == 2'd1) ? din : e1_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = e0_q;
  assign count = cnt_q;
endmodule

// File: rtl/omem_seq.sv
// omem_seq: output-memory port scheduler (engine writes vs ordered readout); OMEM_SEQ_CLEAR_ON_READ_EN zeroes entries as they are read
module omem_seq import omem_pkg::*; (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_req,
  input  logic [OMEM_AW-1:0] wr_addr,
  input  logic [OMEM_DW-1:0] wr_data,
  output logic               wr_ack,
  output logic               wr_err,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OMEM_DW-1:0] out_data,
  output logic [OMEM_AW-1:0] out_addr,
  output logic [OMEM_AW-1:0] mem_bank,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [OMEM_DW-1:0] mem_in,
  input  logic [OMEM_DW-1:0] mem_out
);
  localparam logic [OMEM_AW-1:0] LAST = OMEM_AW'(OMEM_DEPTH - 1);
  localparam logic [OMEM_AW-1:0] DEPTH_A = OMEM_AW'(OMEM_DEPTH);
  state_e state_q, state_d;
  logic [OMEM_AW-1:0] rd_ptr_q, rd_ptr_d, iaddr_q, iaddr_d;
  logic inflight_q, inflight_d, wr_err_q, wr_err_d;
  logic pop, issue, last;
  logic [1:0] fifo_cnt;
  entry_t head, push_e;
  omem_seq_fifo2 u_fifo (
    .clock(clock),
    .reset(reset),
    .push(inflight_q),
    .pop(pop),
    .din(push_e),
    .head(head),
    .count(fifo_cnt)
  );
  always_comb begin
    out_valid = fifo_cnt != 2'd0;
    pop = out_valid && out_ready;
    wr_ack = state_q == IDLE && wr_req;
    issue = state_q == DUMP && ({1'b0, fifo_cnt} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    last = rd_ptr_q == LAST;
    done = state_q == DRAIN && !inflight_q && fifo_cnt == 2'd1 && pop;
    wr_err_d = wr_ack && wr_addr >= DEPTH_A;
    inflight_d = issue;
    iaddr_d = issue ? rd_ptr_q : iaddr_q;
    rd_ptr_d = issue ? (last ? '0 : rd_ptr_q + OMEM_AW'(1)) : rd_ptr_q;
    state_d = (state_q == IDLE && start) ? DUMP :
              (state_q == DUMP && issue && last) ? DRAIN :
              done ? IDLE : state_q;
    busy = state_q != IDLE;
    mem_rd = issue;
    mem_bank = issue ? rd_ptr_q : wr_ack ? wr_addr : '0;
    mem_in = wr_ack ? wr_data : '0;
`ifdef OMEM_SEQ_CLEAR_ON_READ_EN
    mem_wr = issue || (wr_ack && !wr_err_d);
`else
    mem_wr = wr_ack && !wr_err_d;
`endif
    push_e = '{addr: iaddr_q, data: mem_out};
    out_data = head.data;
    out_addr = head.addr;
    wr_err = wr_err_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rd_ptr_q <= '0;
      iaddr_q <= '0;
      inflight_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      iaddr_q <= iaddr_d;
      inflight_q <= inflight_d;
      wr_err_q <= wr_err_d;
    end
  end
endmodule

// File: tb/tb_omem_seq.sv
// tb_omem_seq: randomized self-checking bench for omem_seq against an array model of the memory contents
module tb_omem_seq;
  import omem_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic wr_req = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [OMEM_AW-1:0] wr_addr = '0;
  logic [OMEM_DW-1:0] wr_data = '0;
  logic wr_ack, wr_err, busy, done, out_valid, mem_rd, mem_wr;
  logic [OMEM_DW-1:0] out_data, mem_in;
  logic [OMEM_DW-1:0] mem_out = '0;
  logic [OMEM_AW-1:0] out_addr, mem_bank;
  logic [OMEM_DW-1:0] mem [OMEM_DEPTH];
  logic [OMEM_DW-1:0] ref_mem [OMEM_DEPTH];
  int n_chk = 0, n_pass = 0;
  omem_seq dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .mem_bank(mem_bank), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_in(mem_in), .mem_out(mem_out)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_rd) mem_out <= mem[mem_bank];
    if (mem_wr && mem_bank < OMEM_AW'(OMEM_DEPTH)) mem[mem_bank] <= mem_in;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic write(input logic [OMEM_AW-1:0] a, input logic [OMEM_DW-1:0] d);
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clock);
    chk("wr_ack", wr_ack, 1);
    chk("wr_mem_wr", mem_wr, a < OMEM_DEPTH);
    if (a < OMEM_DEPTH) ref_mem[a] = d;
    @(posedge clock); #1;
    wr_req = 1'b0;
    @(negedge clock);
    chk("wr_err", wr_err, a >= OMEM_DEPTH);
    @(posedge clock); #1;
  endtask
  task automatic fill(input bit rnd);
    for (int k = 0; k < OMEM_DEPTH; k++) write(OMEM_AW'(k), rnd ? OMEM_DW'($urandom) : OMEM_DW'((k + 100) % 512));
  endtask
  task automatic run_dump(input int mode, input bit hold_wr, input bit sw, input bit extra_start, input int abort);
    int got, edges, first;
    bit stalled;
    logic [OMEM_DW-1:0] pd, hd;
    logic [OMEM_AW-1:0] pa, ha;
    got = 0; edges = 0; first = -1; stalled = 0; pd = '0; pa = '0;
    ha = OMEM_AW'($urandom_range(0, OMEM_DEPTH - 1));
    hd = OMEM_DW'($urandom);
    start = 1'b1;
    if (sw) begin
      wr_req = 1'b1;
      wr_addr = OMEM_AW'($urandom_range(0, OMEM_DEPTH - 1));
      wr_data = OMEM_DW'($urandom);
    end
    @(negedge clock);
    chk("start_idle", busy, 0);
    if (sw) begin
      chk("start_wr_ack", wr_ack, 1);
      ref_mem[wr_addr] = wr_data;
    end
    @(posedge clock); #1;
    start = 1'b0;
    wr_req = 1'b0;
    while (got < OMEM_DEPTH && edges < 1000 && !(abort >= 0 && got >= abort)) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (edges % 4 == 0 || edges % 4 == 3) : 1'($urandom_range(0, 1));
      start = extra_start && edges == 5;
      if (hold_wr) begin
        wr_req = 1'b1;
        wr_addr = ha;
        wr_data = hd;
      end
      @(negedge clock);
      chk("busy", busy, 1);
      if (hold_wr) chk("wr_ack_busy", wr_ack, 0);
      if (first < 0 && out_valid) begin
        first = edges;
        chk("latency", edges, 2);
      end
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_addr", out_addr, pa);
      end
      if (out_valid && out_ready) begin
        chk("addr", out_addr, got);
        chk("data", out_data, ref_mem[got]);
        chk("done", done, got == OMEM_DEPTH - 1);
        got++;
      end else chk("done_idle", done, 0);
      stalled = out_valid && !out_ready;
      pd = out_data;
      pa = out_addr;
      @(posedge clock); #1;
      start = 1'b0;
      edges++;
    end
    if (abort >= 0) begin
      reset = 1'b1;
      @(negedge clock);
      chk("abort_done", done, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done2", done, 0);
      @(posedge clock); #1;
      return;
    end
    chk("words", got, OMEM_DEPTH);
    out_ready = 1'b0;
`ifdef OMEM_SEQ_CLEAR_ON_READ_EN
    foreach (ref_mem[i]) ref_mem[i] = '0;
`endif
    @(negedge clock);
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
    if (hold_wr) begin
      chk("held_wr_ack", wr_ack, 1);
      ref_mem[ha] = hd;
    end
    @(posedge clock); #1;
    wr_req = 1'b0;
    if (extra_start) begin
      repeat (4) begin
        @(negedge clock);
        chk("no_redump", busy | out_valid, 0);
      end
      @(posedge clock); #1;
    end
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_outputs", {wr_ack, wr_err, busy, done, out_valid, mem_rd, mem_wr}, 0);
    chk("rst_bank_in", {mem_bank, mem_in}, 0);
    chk("rst_out", {out_data, out_addr}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    fill(0);
    run_dump(0, 0, 0, 0, -1);
    run_dump(1, 0, 0, 0, -1);
    run_dump(2, 1, 1, 1, -1);
    run_dump(0, 0, 0, 0, -1);
    write(OMEM_AW'(75), OMEM_DW'(5));
    @(negedge clock);
    chk("wr_err_once75", wr_err, 0);
    @(posedge clock); #1;
    write(OMEM_AW'(127), OMEM_DW'(6));
    @(negedge clock);
    chk("wr_err_once127", wr_err, 0);
    @(posedge clock); #1;
    fill(1);
    run_dump(0, 0, 0, 0, 30);
    fill(1);
    run_dump(2, 0, 1, 0, -1);
    run_dump(1, 0, 0, 0, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
